// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like responder: size encodings and the queue entry layout.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } sram_size_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } q_entry_t;

  localparam int unsigned EntryW = $bits(q_entry_t);

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: each entry carries its read data and a countdown to completion.
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DELAY = 2
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push,
  input  q_entry_t push_entry,
  output logic     pop,
  output logic     full,
  output q_entry_t head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DlyW = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [DlyW-1:0] dly_q [DEPTH];
  logic [DlyW-1:0] dly_d [DEPTH];
  q_entry_t        entry_q [DEPTH];

  always_comb begin
    pop  = (count_q != '0) && (dly_q[rptr_q] == '0);
    full = (count_q == CntW'(DEPTH));
    head = entry_q[rptr_q];
  end

  always_comb begin
    rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      dly_d[i] = (dly_q[i] != '0) ? dly_q[i] - DlyW'(1) : dly_q[i];
    end
    // When full, push only happens alongside pop, so wptr equals the freed head slot.
    if (push) begin
      dly_d[wptr_q] = DlyW'(DELAY - 1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[wptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like slave with a word memory; reads are sampled at acceptance and returned in order.
module sram_like_resp
  import sram_like_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned RESP_DELAY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_req,
  input  logic        sram_wr,
  input  logic [1:0]  sram_size,
  input  logic [3:0]  sram_wstrb,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic        sram_addr_ok,
  output logic        sram_data_ok,
  output logic [31:0] sram_rdata,
  input  logic        stall_in
);

  logic [31:0]       mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] word_idx;
  logic              accept;
  logic              pop;
  logic              full;
  q_entry_t          push_entry;
  q_entry_t          head;

  // Size is informational only; address bits outside the word index are ignored.
  logic unused_bits;
  assign unused_bits = ^{sram_size, sram_addr[31:ADDR_W+2], sram_addr[1:0]};

  always_comb begin
    word_idx         = sram_addr[ADDR_W+1:2];
    sram_addr_ok     = resetn && !stall_in && (!full || pop);
    accept           = sram_req && sram_addr_ok;
    push_entry.wr    = sram_wr;
    push_entry.rdata = sram_wr ? '0 : mem_q[word_idx];
    sram_data_ok     = pop;
    sram_rdata       = (pop && !head.wr) ? head.rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (accept && sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wstrb[i]) begin
          mem_q[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
  end

  sram_like_resp_fifo #(
    .DEPTH (QDEPTH),
    .DELAY (RESP_DELAY)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .head       (head)
  );

endmodule

// File: tb/tb_sram_like_resp.sv
// Drives three differently parameterised responders with shared stimulus, each against its own model.
module tb_sram_like_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sram_req;
  logic        sram_wr;
  logic [1:0]  sram_size;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        stall_in;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // Expected completion: cycle in which data_ok must be high, plus read data and known-byte mask.
  typedef struct {
    int unsigned due;
    bit          wr;
    logic [31:0] rd;
    logic [31:0] msk;
  } exp_t;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned D = (g == 0) ? 2 : (g == 1) ? 4 : 1;
    localparam int unsigned Q = (g == 2) ? 2 : 4;

    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    sram_like_resp #(
      .ADDR_W     (16),
      .QDEPTH     (Q),
      .RESP_DELAY (D)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .sram_req     (sram_req),
      .sram_wr      (sram_wr),
      .sram_size    (sram_size),
      .sram_wstrb   (sram_wstrb),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_addr_ok (addr_ok),
      .sram_data_ok (data_ok),
      .sram_rdata   (rdata),
      .stall_in     (stall_in)
    );

    exp_t        q[$];
    logic [31:0] mem [int unsigned];
    logic [3:0]  kn  [int unsigned];

    always @(negedge clk) begin
      bit          dok;
      bit          aok;
      logic [31:0] er;
      logic [31:0] em;
      int unsigned idx;
      exp_t        e;
      if (!resetn) q.delete();
      dok = (q.size() > 0) && (q[0].due == cyc);
      er  = (dok && !q[0].wr) ? q[0].rd : 32'h0;
      em  = (dok && !q[0].wr) ? q[0].msk : 32'hFFFF_FFFF;
      aok = resetn && !stall_in && ((q.size() < Q) || dok);
      check($sformatf("data_ok[d%0d]", D), {31'h0, data_ok}, {31'h0, dok});
      check($sformatf("addr_ok[d%0d]", D), {31'h0, addr_ok}, {31'h0, aok});
      check($sformatf("rdata[d%0d]", D), rdata & em, er & em);
      if (dok) void'(q.pop_front());
      if (aok && sram_req) begin
        idx = int'(sram_addr[17:2]);
        if (!mem.exists(idx)) begin
          mem[idx] = 32'h0;
          kn[idx]  = 4'h0;
        end
        e.due = cyc + D;
        e.wr  = sram_wr;
        e.rd  = 32'h0;
        e.msk = 32'hFFFF_FFFF;
        if (sram_wr) begin
          for (int b = 0; b < 4; b++) begin
            if (sram_wstrb[b]) begin
              mem[idx][8*b +: 8] = sram_wdata[8*b +: 8];
              kn[idx][b] = 1'b1;
            end
          end
        end else begin
          e.rd = mem[idx];
          for (int b = 0; b < 4; b++) e.msk[8*b +: 8] = {8{kn[idx][b]}};
        end
        q.push_back(e);
      end
    end
  end

  task automatic drive(input bit req, input bit wr, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] data, input bit stall);
    sram_req   = req;
    sram_wr    = wr;
    sram_wstrb = strb;
    sram_addr  = addr;
    sram_wdata = data;
    sram_size  = 2'd2;
    stall_in   = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    resetn     = 1'b0;
    sram_req   = 1'b0;
    sram_wr    = 1'b0;
    sram_size  = 2'd0;
    sram_wstrb = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    stall_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Full-word write then read back at 0x100.
    drive(1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
    idle(6);
    // Partial strobe write over zero.
    drive(1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 4'h5, 32'h0000_0000, 32'hAABB_CCDD, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'hFFFC_0003, 32'h0, 1'b0);
    idle(6);
    // Five back-to-back reads.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
    idle(8);
    // Two outstanding, then a three-cycle stall with req held.
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
    idle(6);
    // Three outstanding, then a one-cycle reset.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(6);
    // Randomised traffic over a small word pool with junk in the ignored address bits.
    for (int i = 0; i < 3000; i++) begin
      a = $urandom;
      a[17:2] = ($urandom_range(0, 7) == 0) ? 16'h0040 : 16'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) resetn = 1'b0;
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 4'($urandom),
            a, $urandom, ($urandom_range(0, 4) == 0));
      resetn = 1'b1;
    end
    idle(8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
